instr_encoder: RTL
==================

# instr_encoder

Sequential RV32I instruction encoder and program-stream generator for the philv_core test and boot infrastructure. It is the inverse of the core's instruction decoder:
- It accepts decoded operation fields (`alu_funct`, `rs1`/`rs2`/`rd`, `immed`) through a valid/ready handshake.
- It packs them into 32-bit instruction words and emits them with an auto-incrementing byte address toward instruction memory.
- It rejects fields the decoder could not have produced.

## Interface
- `N`, 32, data/immediate width
- `ADDR_W`, 32, output address width
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset; one clock, reset asynchronous and active-low
- `start`  in  1  one-cycle pulse; loads the address counter and begins a program
- `start_addr`  in  `ADDR_W`  first byte address of the program
- `in_valid`  in  1  request valid
- `in_ready`  out  1  request accepted when `in_valid && in_ready`
- `in_class`  in  3  0 = ALU_REG, 1 = ALU_IMM, 2 = LOAD (LW), 3 = STORE (SW); 4–7 illegal
- `in_alu_funct`  in  `ALU_FUNCT_WIDTH`  `ALU_FUNCT_*` code; ignored for LOAD/STORE
- `in_rs1`, `in_rs2`, `in_rd`  in  `INSTR_REG_WIDTH` each  register indices
- `in_immed`  in  `N`  signed immediate, or shift amount for shift ops
- `in_last`  in  1  marks the final request of the program
- `out_valid`  out  1  encoded word valid
- `out_ready`  in  1  word consumed when `out_valid && out_ready`
- `out_instr`  out  32  encoded instruction
- `out_addr`  out  `ADDR_W`  byte address of `out_instr`
- `done`  out  1  one-cycle pulse when the program completes
- `err`  out  1  sticky flag: an illegal request was dropped
- `err_addr`  out  `ADDR_W`  address the first illegal request would have occupied

## Operation
- **FSM: IDLE, LOAD, FLUSH.**
  - IDLE → LOAD on `start`: `addr <= start_addr`, `err <= 0`.
  - LOAD → FLUSH when the request with `in_last=1` is accepted.
  - FLUSH → IDLE when the output register is empty; `done` pulses that cycle.
  - `start` is ignored outside IDLE.
- **Handshake.** `in_ready = (state==LOAD) && (!out_valid || out_ready)`.
- **Field encoding** (rs1→[19:15], rs2→[24:20], rd→[11:7]):
  - **ALU_REG:** opcode `OPCODE_ALU_REG`; funct3 from `alu_funct`. funct7 = `FUNCT7_ALT1` for SUB/SRA, otherwise `FUNCT7_BASE`.
  - **ALU_IMM:** opcode `OPCODE_ALU_IMM`.
    - Non-shifts: [31:20] = `immed[11:0]`.
    - SLL/SRL/SRA: [31:25] = funct7, [24:20] = `immed[4:0]`.
    - rs2 ignored.
  - **LOAD:** opcode `OPCODE_LOAD`, funct3 = 010, [31:20] = `immed[11:0]`.
  - **STORE:** opcode `OPCODE_STORE`, funct3 = 010, [31:25] = `immed[11:5]`, [11:7] = `immed[4:0]`; rd ignored.
- **Illegal request.** Any of the following:
  - class 4–7;
  - SUB with class ALU_IMM;
  - an unknown `alu_funct`;
  - a non-shift immediate where `immed[N-1:11]` is not all-equal;
  - a shift amount where `immed[N-1:5] != 0`.
- **Handling an illegal request.** It is accepted (handshake completes) but produces no output word.
  - The address does not advance.
  - On the first error, `err` sets and `err_addr <= addr`; later errors leave `err_addr` unchanged.
  - An illegal request with `in_last=1` still ends the program.
- **Address.** Advances by 4 per emitted word, modulo 2^`ADDR_W`; wrap-around is silent.

## Timing
- **Reset values:** state IDLE; `in_ready` 0, `out_valid` 0, `out_instr` 0, `out_addr` 0, `done` 0, `err` 0, `err_addr` 0. Internal address counter 0.
- **Latency:** a legal request accepted at edge k gives `out_valid=1` after edge k, with `out_instr`/`out_addr` registered.
- **Throughput:** 1 word/cycle when `out_ready` is held high.
- **Backpressure:** while `out_valid && !out_ready`, the output holds stable and `in_ready=0`.
- **Simultaneous output consume and new accept:** the output register reloads in the same edge, with no bubble.
- **`done` timing:** `done` is asserted in the cycle after the last word is consumed. If the last request was illegal, or was accepted with the output register already empty, `done` is asserted in the cycle after acceptance.
- **Reset mid-program:** everything returns to reset values immediately; any pending word is lost.

## Test plan
- **ALU_REG:** `start_addr=0x100`, then ADD rd=3 rs1=1 rs2=2 → `out_instr=0x002081B3`, `out_addr=0x100`. Next, SUB rd=5 rs1=6 rs2=7 → `0x407302B3` @ `0x104`.
- **ALU_IMM:** ADD immed=0xFFFFFFFF rd=1 rs1=0 → `0xFFF00093`. SRA rd=2 rs1=2 immed=3 → `0x40315113`.
- **LOAD/STORE:** STORE rs1=1 rs2=2 immed=8 → `0x0020A423`. LOAD rd=4 rs1=3 immed=-4 → `0xFFC1A203`. Both are consecutive words with addresses 4 apart.
- **Illegal then legal:** `start_addr=0x200`; ALU_IMM ADD immed=0x800 → no output, `err=1`, `err_addr=0x200`. The next legal word is emitted at `0x200`.
- **Backpressure and wrap:** `start_addr=0xFFFFFFFC`, 3 requests, `out_ready` low for 4 cycles → the first word is held stable and `in_ready=0`. Emitted addresses are `0xFFFFFFFC`, `0x0`, `0x4`. `done` pulses once, after the third consume.
- **Reset mid-program:** assert `rst_n=0` with `out_valid=1` → all outputs go to 0 asynchronously. A `start` after release begins cleanly at the new `start_addr`.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Request/response bundle between a program source and the RV32I instruction encoder.
// The request side carries decoded fields in; the response side carries encoded words out.
interface instr_encoder_if #(
  parameter int N               = 32,
  parameter int ADDR_W          = 32,
  parameter int ALU_FUNCT_WIDTH = 4,
  parameter int INSTR_REG_WIDTH = 5
);
  logic                       in_valid;
  logic                       in_ready;
  logic [2:0]                 in_class;
  logic [ALU_FUNCT_WIDTH-1:0] in_alu_funct;
  logic [INSTR_REG_WIDTH-1:0] in_rs1;
  logic [INSTR_REG_WIDTH-1:0] in_rs2;
  logic [INSTR_REG_WIDTH-1:0] in_rd;
  logic [N-1:0]               in_immed;
  logic                       in_last;
  logic                       out_valid;
  logic                       out_ready;
  logic [31:0]                out_instr;
  logic [ADDR_W-1:0]          out_addr;

  modport master (
    output in_valid, in_class, in_alu_funct, in_rs1, in_rs2, in_rd, in_immed, in_last,
    input  in_ready,
    output out_ready,
    input  out_valid, out_instr, out_addr
  );

  modport slave (
    input  in_valid, in_class, in_alu_funct, in_rs1, in_rs2, in_rd, in_immed, in_last,
    output in_ready,
    input  out_ready,
    output out_valid, out_instr, out_addr
  );
endinterface

// File: rtl/instr_encoder.sv
// Sequential RV32I encoder: packs decoded fields into instruction words with an
// auto-incrementing byte address, dropping (and flagging) requests no decoder could emit.
module instr_encoder #(
  parameter int N               = 32,
  parameter int ADDR_W          = 32,
  parameter int ALU_FUNCT_WIDTH = 4,
  parameter int INSTR_REG_WIDTH = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  instr_encoder_if.slave    bus,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr
);

  localparam logic [2:0] CLS_ALU_REG = 3'd0;
  localparam logic [2:0] CLS_ALU_IMM = 3'd1;
  localparam logic [2:0] CLS_LOAD    = 3'd2;
  localparam logic [2:0] CLS_STORE   = 3'd3;

  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_ADD  = 'd0;
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_SUB  = 'd1;
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_SLL  = 'd2;
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_SLT  = 'd3;
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_SLTU = 'd4;
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_XOR  = 'd5;
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_SRL  = 'd6;
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_SRA  = 'd7;
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_OR   = 'd8;
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_AND  = 'd9;

  localparam logic [6:0] OPCODE_ALU_REG = 7'b0110011;
  localparam logic [6:0] OPCODE_ALU_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_LOAD    = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE   = 7'b0100011;
  localparam logic [6:0] FUNCT7_BASE    = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT1    = 7'b0100000;
  localparam logic [2:0] FUNCT3_WORD    = 3'b010;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH} state_t;

  typedef struct packed {
    logic [2:0]                 cls;
    logic [ALU_FUNCT_WIDTH-1:0] funct;
    logic [INSTR_REG_WIDTH-1:0] rs1;
    logic [INSTR_REG_WIDTH-1:0] rs2;
    logic [INSTR_REG_WIDTH-1:0] rd;
    logic [N-1:0]               imm;
    logic                       last;
  } req_t;

  state_t            state, state_nxt;
  req_t              req;
  logic              in_rdy;
  logic              accept;
  logic              legal;
  logic [31:0]       enc;
  logic [ADDR_W-1:0] addr;
  logic              out_valid_q;
  logic [31:0]       out_instr_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic              err_q;
  logic [ADDR_W-1:0] err_addr_q;

  assign req = '{cls:   bus.in_class,
                 funct: bus.in_alu_funct,
                 rs1:   bus.in_rs1,
                 rs2:   bus.in_rs2,
                 rd:    bus.in_rd,
                 imm:   bus.in_immed,
                 last:  bus.in_last};

  assign accept        = bus.in_valid && in_rdy;
  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_addr  = out_addr_q;
  assign err           = err_q;
  assign err_addr      = err_addr_q;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD: begin
        in_rdy = !out_valid_q || bus.out_ready;
        if (bus.in_valid && in_rdy && bus.in_last) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        // Output register drained: the program is complete this cycle.
        if (!out_valid_q) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------- field packing and legality ----------------
  logic [2:0] f3;
  logic [6:0] f7;
  logic       funct_known;
  logic       is_shift;
  logic       imm12_ok;
  logic       shamt_ok;

  always_comb begin
    f3          = 3'b000;
    funct_known = 1'b1;
    case (req.funct)
      ALU_FUNCT_ADD, ALU_FUNCT_SUB: f3 = 3'b000;
      ALU_FUNCT_SLL:                f3 = 3'b001;
      ALU_FUNCT_SLT:                f3 = 3'b010;
      ALU_FUNCT_SLTU:               f3 = 3'b011;
      ALU_FUNCT_XOR:                f3 = 3'b100;
      ALU_FUNCT_SRL, ALU_FUNCT_SRA: f3 = 3'b101;
      ALU_FUNCT_OR:                 f3 = 3'b110;
      ALU_FUNCT_AND:                f3 = 3'b111;
      default:                      funct_known = 1'b0;
    endcase
  end

  assign is_shift = (req.funct == ALU_FUNCT_SLL) || (req.funct == ALU_FUNCT_SRL) ||
                    (req.funct == ALU_FUNCT_SRA);
  assign f7       = ((req.funct == ALU_FUNCT_SUB) || (req.funct == ALU_FUNCT_SRA)) ?
                    FUNCT7_ALT1 : FUNCT7_BASE;
  // A 12-bit signed immediate fits when every bit from 11 upward equals the sign.
  assign imm12_ok = (&req.imm[N-1:11]) || !(|req.imm[N-1:11]);
  assign shamt_ok = !(|req.imm[N-1:5]);

  always_comb begin
    enc   = 32'd0;
    legal = 1'b0;
    case (req.cls)
      CLS_ALU_REG: begin
        legal = funct_known;
        enc   = {f7, req.rs2, req.rs1, f3, req.rd, OPCODE_ALU_REG};
      end
      CLS_ALU_IMM: begin
        legal = funct_known && (req.funct != ALU_FUNCT_SUB) &&
                (is_shift ? shamt_ok : imm12_ok);
        if (is_shift) enc = {f7, req.imm[4:0], req.rs1, f3, req.rd, OPCODE_ALU_IMM};
        else          enc = {req.imm[11:0], req.rs1, f3, req.rd, OPCODE_ALU_IMM};
      end
      CLS_LOAD: begin
        legal = imm12_ok;
        enc   = {req.imm[11:0], req.rs1, FUNCT3_WORD, req.rd, OPCODE_LOAD};
      end
      CLS_STORE: begin
        legal = imm12_ok;
        enc   = {req.imm[11:5], req.rs2, req.rs1, FUNCT3_WORD, req.imm[4:0], OPCODE_STORE};
      end
      default: legal = 1'b0;
    endcase
  end

  // ---------------- address, output register, error capture ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr        <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_addr_q  <= '0;
      err_q       <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        addr  <= start_addr;
        err_q <= 1'b0;
      end
      // Accept implies the current word is absent or leaving, so reload with no bubble.
      if (accept && legal) begin
        out_valid_q <= 1'b1;
        out_instr_q <= enc;
        out_addr_q  <= addr;
        addr        <= addr + ADDR_W'(4);
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (accept && !legal) begin
        err_q <= 1'b1;
        if (!err_q) err_addr_q <= addr;
      end
    end
  end

endmodule
